// File: rtl/cmd_host_seq.sv
// rtl/cmd_host_seq.sv - queued host command sequencer over UART 8N1 with response ack/timeout check
//
// Queues up to FIFO_DEPTH commands ({opcode, DATA_BYTES payload}), sends each one
// as UART 8N1 frames (opcode first, then payload MSB byte first), then waits for a
// one-byte response and reports ack_ok or a sticky error per command.
//
// Optional macro: RETRY_EN - retransmit a failed command up to MAX_RETRY times
// before raising err. Without it, MAX_RETRY has no effect.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd, data, send_cmd   command to enqueue and its 1-cycle enqueue strobe
//   cmd_full, cmd_cnt     queue full flag, entries waiting (in-flight one excluded)
//   busy                  a command is being transmitted or awaiting its response
//   TX, RX                UART serial out (idle high) / serial in (asynchronous)
//   resp, resp_rdy        last received byte, sticky received flag
//   clr_resp_rdy          clears resp_rdy
//   ack_ok                1-cycle pulse when the in-flight command is acknowledged
//   err, err_code         sticky error flag, first error cause (01 NAK, 10 timeout)
//   clr_err               clears err and err_code
module cmd_host_seq #(
    parameter int         DATA_BYTES = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter int         BAUD_DIV   = 2604,
    parameter int         TIMEOUT    = 500000,
    parameter logic [7:0] POS_ACK    = 8'hA5,
    parameter int         MAX_RETRY  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    cmd,
    input  logic [8*DATA_BYTES-1:0]       data,
    input  logic                          send_cmd,
    output logic                          cmd_full,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_cnt,
    output logic                          busy,
    output logic                          TX,
    input  logic                          RX,
    output logic [7:0]                    resp,
    output logic                          resp_rdy,
    input  logic                          clr_resp_rdy,
    output logic                          ack_ok,
    output logic                          err,
    output logic [1:0]                    err_code,
    input  logic                          clr_err
);

    localparam int W  = 8 * (DATA_BYTES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef RETRY_EN
    localparam int RETRY_LIMIT = MAX_RETRY;
`else
    // No retransmission: every failure is final.
    localparam int RETRY_LIMIT = 0 * MAX_RETRY;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX_BYTE,
        S_TX_WAIT,
        S_RESP_WAIT
    } state_t;

    state_t state, state_n;

    // ---------------- command queue ----------------
    logic [W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign cmd_full = (count == CW'(FIFO_DEPTH));
    assign cmd_cnt  = count;
    assign push     = send_cmd && !cmd_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd, data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_active;
    logic [3:0]    rx_bit;
    logic [BW-1:0] rx_baud;
    logic [7:0]    rx_shift;
    logic          rx_done;

    // rx_bit 0 is the start bit, 1..8 data, 9 stop; a byte is valid only if the
    // stop bit samples high.
    assign rx_done = rx_active && (rx_bit == 4'd9) && (rx_baud == BW'(BAUD_DIV - 1)) && rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_bit    <= '0;
            rx_baud   <= '0;
            rx_shift  <= '0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_bit    <= '0;
                    rx_baud   <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                // Half a bit after the falling edge: the line must still be low.
                if (rx_baud == BW'(BAUD_DIV / 2 - 1)) begin
                    if (rx_s2) begin
                        rx_active <= 1'b0;
                    end else begin
                        rx_bit  <= 4'd1;
                        rx_baud <= '0;
                    end
                end else begin
                    rx_baud <= rx_baud + BW'(1);
                end
            end else if (rx_baud == BW'(BAUD_DIV - 1)) begin
                rx_baud <= '0;
                if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_baud <= rx_baud + BW'(1);
            end
        end
    end

    // ---------------- transmit / response sequencer ----------------
    logic [W-1:0]  cmd_hold;
    logic [2:0]    byte_idx;
    logic [7:0]    cur_byte;
    logic [9:0]    tx_frame;
    logic [3:0]    tx_bit;
    logic [BW-1:0] tx_baud;
    logic [TW-1:0] to_cnt;
    logic [7:0]    retry_cnt;
    logic          last_byte, to_hit;
    logic          retry, ack_set, err_set;
    logic [1:0]    err_kind;

    // byte_idx has already advanced past the byte on the wire while in TX_WAIT.
    assign last_byte = (byte_idx == 3'(DATA_BYTES + 1));
    // The timeout is frozen while a response byte is being received.
    assign to_hit    = !rx_active && (to_cnt == TW'(TIMEOUT - 1));
    assign busy      = (state != S_IDLE);
    assign TX        = (state == S_TX_WAIT) ? tx_frame[0] : 1'b1;

    always_comb begin
        cur_byte = cmd_hold[W-1 -: 8];
        for (int i = 1; i <= DATA_BYTES; i++) begin
            if (byte_idx == 3'(i)) cur_byte = cmd_hold[W-1-8*i -: 8];
        end
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        retry    = 1'b0;
        ack_set  = 1'b0;
        err_set  = 1'b0;
        err_kind = 2'b00;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = S_TX_BYTE;
                end
            end
            S_TX_BYTE: state_n = S_TX_WAIT;
            S_TX_WAIT: begin
                // Between bytes the stop bit ends one cycle early; the TX_BYTE
                // cycle (line held high) completes it, so frames stay gapless.
                if (tx_bit == 4'd9) begin
                    if (!last_byte && tx_baud == BW'(BAUD_DIV - 2))
                        state_n = S_TX_BYTE;
                    else if (last_byte && tx_baud == BW'(BAUD_DIV - 1))
                        state_n = S_RESP_WAIT;
                end
            end
            S_RESP_WAIT: begin
                if (rx_done || to_hit) begin
                    err_kind = rx_done ? 2'b01 : 2'b10;
                    if (rx_done && rx_shift == POS_ACK) begin
                        ack_set = 1'b1;
                        state_n = S_IDLE;
                    end else if (retry_cnt != 8'(RETRY_LIMIT)) begin
                        retry   = 1'b1;
                        state_n = S_TX_BYTE;
                    end else begin
                        err_set = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_hold  <= '0;
            byte_idx  <= '0;
            tx_frame  <= '1;
            tx_bit    <= '0;
            tx_baud   <= '0;
            to_cnt    <= '0;
            retry_cnt <= '0;
            ack_ok    <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            resp      <= '0;
            resp_rdy  <= 1'b0;
        end else begin
            state  <= state_n;
            ack_ok <= ack_set;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cmd_hold  <= fifo_mem[rd_ptr];
                        byte_idx  <= '0;
                        retry_cnt <= '0;
                    end
                end
                S_TX_BYTE: begin
                    tx_frame <= {1'b1, cur_byte, 1'b0};
                    tx_bit   <= '0;
                    tx_baud  <= '0;
                    byte_idx <= byte_idx + 3'd1;
                end
                S_TX_WAIT: begin
                    to_cnt <= '0;
                    if (tx_baud == BW'(BAUD_DIV - 1)) begin
                        tx_baud  <= '0;
                        tx_bit   <= tx_bit + 4'd1;
                        tx_frame <= {1'b1, tx_frame[9:1]};
                    end else begin
                        tx_baud <= tx_baud + BW'(1);
                    end
                end
                S_RESP_WAIT: begin
                    if (retry) begin
                        byte_idx  <= '0;
                        retry_cnt <= retry_cnt + 8'd1;
                    end else if (!rx_active) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: ;
            endcase

            if (err_set) begin
                err <= 1'b1;
                if (!err) err_code <= err_kind;
            end else if (clr_err) begin
                err      <= 1'b0;
                err_code <= 2'b00;
            end

            if (rx_done) begin
                resp     <= rx_shift;
                resp_rdy <= 1'b1;
            end else if (clr_resp_rdy) begin
                resp_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_host_seq.sv
// tb/tb_cmd_host_seq.sv - self-checking bench for cmd_host_seq
module tb_cmd_host_seq;
    localparam int BAUD = 16;
    localparam int TMO  = 2000;
    localparam int MAXR = 2;
`ifdef RETRY_EN
    localparam int FAIL_ATTEMPTS = 1 + MAXR;
`else
    localparam int FAIL_ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd = '0;
    logic [15:0] data = '0;
    logic        send_cmd = 1'b0;
    logic        cmd_full;
    logic [2:0]  cmd_cnt;
    logic        busy;
    logic        TX;
    logic        RX = 1'b1;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy = 1'b0;
    logic        ack_ok;
    logic        err;
    logic [1:0]  err_code;
    logic        clr_err = 1'b0;

    cmd_host_seq #(
        .DATA_BYTES(2), .FIFO_DEPTH(4), .BAUD_DIV(BAUD), .TIMEOUT(TMO),
        .POS_ACK(8'hA5), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .data(data), .send_cmd(send_cmd),
        .cmd_full(cmd_full), .cmd_cnt(cmd_cnt), .busy(busy), .TX(TX), .RX(RX),
        .resp(resp), .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy),
        .ack_ok(ack_ok), .err(err), .err_code(err_code), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    int         tx_fall_cnt = 0;
    int         n_stop_err = 0;
    int         last_stop_end = 0;
    logic [7:0] tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ack_ok === 1'b1) ack_cnt <= ack_cnt + 1;
    always @(negedge TX) tx_fall_cnt <= tx_fall_cnt + 1;

    // TX line decoder: samples each bit at its centre.
    initial begin
        forever begin
            automatic int         c0;
            automatic logic [7:0] b;
            @(negedge TX);
            c0 = cyc;
            repeat (BAUD / 2) @(posedge clk);
            #1;
            if (TX === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(posedge clk);
                    #1 b[i] = TX;
                end
                repeat (BAUD) @(posedge clk);
                #1;
                if (TX !== 1'b1) n_stop_err++;
                tx_q.push_back(b);
                last_stop_end = c0 + 10 * BAUD;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] c, input logic [15:0] d);
        @(negedge clk);
        cmd = c; data = d; send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 4000 && tx_q.size() < n; i++) @(negedge clk);
        chk("tx_bytes_seen", tx_q.size(), n);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = stop;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_err = 1'b1; clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_err = 1'b0; clr_resp_rdy = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_err_code", err_code, 0);
        chk("clr_resp_rdy", resp_rdy, 0);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic        clr;       // clear err/resp_rdy before the command
        logic        reply;     // responder sends a byte
        logic [7:0]  rbyte;
        logic        rstop;     // stop bit value of the reply
        int          exp_ack;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic        exp_rdy;
        logic [7:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         attempts, done_cyc, a0, f0;
        logic       e_at_drop;
        logic [1:0] ec_at_drop;

        vecs[0] = '{8'h05, 16'h00A0, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 1'b0, 2'b00, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 16'h1234, 1'b1, 1'b1, 8'h5A, 1'b1, 0, 1'b1, 2'b01, 1'b1, 8'h5A};
        vecs[2] = '{8'h81, 16'hFFFF, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 2'b01, 1'b1, 8'h5A};
        vecs[3] = '{8'h42, 16'h8001, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 2'b10, 1'b0, 8'h5A};
        vecs[4] = '{8'h7E, 16'h0001, 1'b1, 1'b1, 8'hA5, 1'b0, 0, 1'b1, 2'b10, 1'b0, 8'h5A};
        vecs[5] = '{8'hC3, 16'h8000, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 1'b0, 2'b00, 1'b1, 8'hA5};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_TX", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_rdy", resp_rdy, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_full", cmd_full, 0);
        chk("rst_resp", resp, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_cmd_cnt", cmd_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-command vectors
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].clr) clear_flags();
            tx_q.delete();
            a0 = ack_cnt;
            attempts = (vecs[v].exp_ack != 0) ? 1 : FAIL_ATTEMPTS;
            push_cmd(vecs[v].cmd, vecs[v].data);
            for (int a = 0; a < attempts; a++) begin
                wait_bytes(3 * (a + 1));
                repeat (20) @(negedge clk);
                if (vecs[v].reply) send_rx(vecs[v].rbyte, vecs[v].rstop);
            end
            done_cyc = -1;
            for (int i = 0; i < 6000; i++) begin
                if (!busy) begin
                    done_cyc = cyc;
                    break;
                end
                @(negedge clk);
            end
            e_at_drop = err;
            ec_at_drop = err_code;
            chk("busy_dropped", busy, 0);
            repeat (2) @(negedge clk);
            chk("tx_count", tx_q.size(), 3 * attempts);
            chk("tx_cmd_byte", tx_q[0], vecs[v].cmd);
            chk("tx_data_hi", tx_q[1], vecs[v].data[15:8]);
            chk("tx_data_lo", tx_q[2], vecs[v].data[7:0]);
            chk("ack_pulses", ack_cnt - a0, vecs[v].exp_ack);
            chk("err_at_busy_drop", e_at_drop, vecs[v].exp_err);
            chk("err_code", ec_at_drop, vecs[v].exp_code);
            chk("resp_rdy", resp_rdy, vecs[v].exp_rdy);
            chk("resp", resp, vecs[v].exp_resp);
            if (!vecs[v].reply) chk("timeout_latency", done_cyc - last_stop_end, TMO);
        end

        // Queue fill: five back-to-back pushes, the first pops after one cycle
        clear_flags();
        tx_q.delete();
        a0 = ack_cnt;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            cmd = 8'h10 + 8'(k);
            data = {8'h20 + 8'(k), 8'h30 + 8'(k)};
            send_cmd = 1'b1;
            @(negedge clk);
        end
        send_cmd = 1'b0;
        chk("q_cnt_full", cmd_cnt, 4);
        chk("q_full", cmd_full, 1);
        chk("q_busy", busy, 1);
        cmd = 8'hEE; data = 16'hEEEE; send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        @(negedge clk);
        chk("q_drop_cnt", cmd_cnt, 4);
        chk("q_drop_full", cmd_full, 1);
        for (int k = 0; k < 5; k++) begin
            wait_bytes(3 * (k + 1));
            repeat (20) @(negedge clk);
            send_rx(8'hA5, 1'b1);
        end
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        chk("q_total_bytes", tx_q.size(), 15);
        for (int k = 0; k < 5; k++) begin
            chk("q_order_cmd", tx_q[3*k], 8'h10 + 8'(k));
            chk("q_order_hi", tx_q[3*k+1], 8'h20 + 8'(k));
            chk("q_order_lo", tx_q[3*k+2], 8'h30 + 8'(k));
        end
        chk("q_acks", ack_cnt - a0, 5);
        chk("q_cnt_empty", cmd_cnt, 0);
        chk("q_not_full", cmd_full, 0);
        chk("q_idle", busy, 0);
        chk("q_no_err", err, 0);

        // Reset in the middle of data bit 0 of the second byte
        tx_q.delete();
        push_cmd(8'h55, 16'h1234);
        push_cmd(8'h66, 16'h5678);
        chk("r_cnt_before", cmd_cnt, 1);
        wait_bytes(1);
        repeat (32) @(negedge clk);
        chk("r_tx_low_before", TX, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("r_tx_async_high", TX, 1);
        chk("r_busy_async", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("r_cnt_after", cmd_cnt, 0);
        chk("r_busy_after", busy, 0);
        chk("r_full_after", cmd_full, 0);
        f0 = tx_fall_cnt;
        repeat (300) @(negedge clk);
        chk("r_no_frame", tx_fall_cnt - f0, 0);
        chk("tx_stop_bits", n_stop_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
